// File: rtl/processor_controller.sv
// Multi-cycle control FSM for a small register-bus processor: LOAD, MOV and ALU ops.
// Optional macro STEP_MODE_EN adds a STEP port that gates every transition out of T1-T3.
module processor_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] INSTR,
    input  logic       EXEC,
`ifdef STEP_MODE_EN
    input  logic       STEP,
`endif
    output logic       IRin,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       Extern,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic [3:0] FN,
    output logic       Done,
    output logic       Busy
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [9:0]  r_ir;

    logic [3:0]  w_opcode;
    logic        w_isLoad;
    logic        w_isMov;
    logic [3:0]  w_rxHot;
    logic [3:0]  w_ryHot;
    logic        w_adv;

    assign w_opcode = r_ir[9:6];
    assign w_isLoad = (w_opcode == 4'b0000);
    assign w_isMov  = (w_opcode == 4'b0001);
    assign w_rxHot  = 4'b0001 << r_ir[5:4];
    assign w_ryHot  = 4'b0001 << r_ir[3:2];

    // Write strobes and Done fire only on the cycle the state actually advances.
`ifdef STEP_MODE_EN
    assign w_adv = STEP;
`else
    assign w_adv = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && EXEC) begin
                r_ir <= INSTR;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        IRin   = 1'b0;
        Rin    = 4'b0000;
        Rout   = 4'b0000;
        Extern = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        FN     = 4'b0000;
        Done   = 1'b0;
        Busy   = (r_state != T0);

        case (r_state)
            T0: begin
                if (EXEC) begin
                    IRin   = 1'b1;
                    w_next = T1;
                end
            end
            T1: begin
                if (w_isLoad) begin
                    Extern = 1'b1;
                    Rin    = w_adv ? w_rxHot : 4'b0000;
                    Done   = w_adv;
                    w_next = w_adv ? T0 : T1;
                end else if (w_isMov) begin
                    Rout   = w_ryHot;
                    Rin    = w_adv ? w_rxHot : 4'b0000;
                    Done   = w_adv;
                    w_next = w_adv ? T0 : T1;
                end else begin
                    Rout   = w_rxHot;
                    Ain    = w_adv;
                    FN     = w_opcode;
                    w_next = w_adv ? T2 : T1;
                end
            end
            T2: begin
                Rout   = w_ryHot;
                Gin    = w_adv;
                FN     = w_opcode;
                w_next = w_adv ? T3 : T2;
            end
            T3: begin
                Gout   = 1'b1;
                Rin    = w_adv ? w_rxHot : 4'b0000;
                Done   = w_adv;
                FN     = w_opcode;
                w_next = w_adv ? T0 : T3;
            end
            default: w_next = T0;
        endcase

        // Reset silences every output immediately, not just after the edge.
        if (!rst_n) begin
            w_next = T0;
            IRin   = 1'b0;
            Rin    = 4'b0000;
            Rout   = 4'b0000;
            Extern = 1'b0;
            Ain    = 1'b0;
            Gin    = 1'b0;
            Gout   = 1'b0;
            FN     = 4'b0000;
            Done   = 1'b0;
            Busy   = 1'b0;
        end
    end

endmodule

// File: tb/tb_processor_controller.sv
// Self-checking bench for processor_controller: directed cases plus a randomized run
// against a phase-counting reference model.
module tb_processor_controller;

    logic       clk;
    logic       rst_n;
    logic [9:0] INSTR;
    logic       EXEC;
`ifdef STEP_MODE_EN
    logic       STEP;
`endif
    logic       IRin;
    logic [3:0] Rin;
    logic [3:0] Rout;
    logic       Extern;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic [3:0] FN;
    logic       Done;
    logic       Busy;

    int errors = 0;
    int checks = 0;

    processor_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INSTR  (INSTR),
        .EXEC   (EXEC),
`ifdef STEP_MODE_EN
        .STEP   (STEP),
`endif
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Extern (Extern),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .FN     (FN),
        .Done   (Done),
        .Busy   (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {IRin, Rin, Rout, Extern, Ain, Gin, Gout, FN, Done, Busy}
    function automatic logic [18:0] obsOut();
        return {IRin, Rin, Rout, Extern, Ain, Gin, Gout, FN, Done, Busy};
    endfunction

    // Expected outputs for a cycle: phase 0 is idle, 1..3 are the instruction steps.
    function automatic logic [18:0] expOut(input int phase, input logic [9:0] ir,
                                           input logic exec, input logic adv);
        logic [3:0] op;
        logic [3:0] rx;
        logic [3:0] ry;
        logic       eIrin, eExt, eAin, eGin, eGout, eDone, eBusy;
        logic [3:0] eRin, eRout, eFn;
        op = ir[9:6];
        rx = 4'b0001 << ir[5:4];
        ry = 4'b0001 << ir[3:2];
        eIrin = 0; eExt = 0; eAin = 0; eGin = 0; eGout = 0; eDone = 0;
        eRin = 0; eRout = 0; eFn = 0;
        eBusy = (phase != 0);
        if (phase == 0) begin
            eIrin = exec;
        end else if (phase == 1 && op == 4'd0) begin
            eExt = 1; eRin = adv ? rx : 4'd0; eDone = adv;
        end else if (phase == 1 && op == 4'd1) begin
            eRout = ry; eRin = adv ? rx : 4'd0; eDone = adv;
        end else if (phase == 1) begin
            eRout = rx; eAin = adv; eFn = op;
        end else if (phase == 2) begin
            eRout = ry; eGin = adv; eFn = op;
        end else begin
            eGout = 1; eRin = adv ? rx : 4'd0; eDone = adv; eFn = op;
        end
        return {eIrin, eRin, eRout, eExt, eAin, eGin, eGout, eFn, eDone, eBusy};
    endfunction

    // Drives one cycle of inputs just after a rising edge and lets outputs settle.
    task automatic drive(input logic [9:0] instr, input logic exec, input logic rstn);
        @(posedge clk);
        #1;
        INSTR = instr;
        EXEC  = exec;
        rst_n = rstn;
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] obs;
        for (int i = 0; i < 3; i++) begin
            drive(10'($urandom), 1'b1, 1'b0);
            obs = obsOut();
            checks++;
            if (obs !== 19'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
            end
        end
        drive(10'b0000_01_00_00, 1'b0, 1'b1);
        checks++;
        if (Busy !== 1'b0 || IRin !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: Busy=%b IRin=%b expected 0 0", Busy, IRin);
        end
    endtask

    // Runs one instruction from an EXEC pulse and checks every cycle until idle again.
    task automatic runInstr(input string name, input logic [9:0] instr);
        logic [18:0] obs;
        logic [18:0] exp;
        int len;
        len = (instr[9:6] < 4'd2) ? 1 : 3;
        drive(instr, 1'b1, 1'b1);
        for (int p = 0; p <= len + 1; p++) begin
            if (p > 0) drive(10'($urandom), 1'b0, 1'b1);
            exp = expOut((p > len) ? 0 : p, instr, (p == 0), 1'b1);
            obs = obsOut();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("[TB] FAIL %s phase %0d: got %h expected %h", name, p, obs, exp);
            end
        end
    endtask

    task automatic test_load();
        runInstr("load_r1", 10'b0000_01_00_00);
    endtask

    task automatic test_mov();
        runInstr("mov_r3_r2", 10'b0001_11_10_00);
    endtask

    task automatic test_alu();
        runInstr("alu_0101_r0_r3", 10'b0101_00_11_00);
        runInstr("alu_same_reg", 10'b1111_10_10_00);
    endtask

    task automatic test_abort();
        logic [9:0] ir;
        ir = 10'b1010_10_01_00;
        drive(ir, 1'b1, 1'b1);
        drive(ir, 1'b0, 1'b1);
        drive(10'b0000_11_00_00, 1'b1, 1'b1);
        checks++;
        if (obsOut() !== expOut(2, ir, 1'b0, 1'b1)) begin
            errors++;
            $display("[TB] FAIL abort_t2_ignore: got %h expected %h", obsOut(), expOut(2, ir, 1'b0, 1'b1));
        end
        drive(ir, 1'b0, 1'b0);
        checks++;
        if (obsOut() !== 19'd0) begin
            errors++;
            $display("[TB] FAIL abort_in_reset: got %h expected 0", obsOut());
        end
        drive(ir, 1'b0, 1'b1);
        checks++;
        if (Rin !== 4'd0 || Done !== 1'b0 || Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_after: Rin=%b Done=%b Busy=%b expected 0000 0 0", Rin, Done, Busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] a;
        logic [9:0] b;
        a = 10'b0000_10_00_00;
        b = 10'b0001_00_01_00;
        drive(a, 1'b1, 1'b1);
        drive(b, 1'b1, 1'b1);
        checks++;
        if (obsOut() !== expOut(1, a, 1'b0, 1'b1)) begin
            errors++;
            $display("[TB] FAIL b2b_first: got %h expected %h", obsOut(), expOut(1, a, 1'b0, 1'b1));
        end
        drive(b, 1'b1, 1'b1);
        checks++;
        if (IRin !== 1'b1 || Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_restart: IRin=%b Busy=%b expected 1 0", IRin, Busy);
        end
        drive(a, 1'b0, 1'b1);
        checks++;
        if (obsOut() !== expOut(1, b, 1'b0, 1'b1)) begin
            errors++;
            $display("[TB] FAIL b2b_second: got %h expected %h", obsOut(), expOut(1, b, 1'b0, 1'b1));
        end
        drive(a, 1'b0, 1'b1);
    endtask

    // Random INSTR/EXEC every cycle; model tracks only which step of the instruction is live.
    task automatic test_random();
        int phase;
        logic [9:0] ir;
        logic [9:0] instr;
        logic exec;
        logic adv;
        logic [18:0] exp;
        phase = 0;
        ir = '0;
        for (int i = 0; i < 400 || phase != 0; i++) begin
            instr = 10'($urandom);
            exec  = (i < 400) ? ($urandom_range(0, 3) != 0) : 1'b0;
            adv   = 1'b1;
`ifdef STEP_MODE_EN
            adv  = ($urandom_range(0, 2) == 0);
            STEP = adv;
`endif
            drive(instr, exec, 1'b1);
            exp = (phase == 0) ? expOut(0, instr, exec, adv) : expOut(phase, ir, 1'b0, adv);
            checks++;
            if (obsOut() !== exp) begin
                errors++;
                $display("[TB] FAIL random cycle %0d phase %0d: got %h expected %h", i, phase, obsOut(), exp);
            end
            checks++;
            if ($countones(Rin) > 1 || $countones(Rout) > 1 ||
                (int'(Extern) + int'(Gout) + int'(Rout != 0)) > 1) begin
                errors++;
                $display("[TB] FAIL exclusivity cycle %0d: Rin=%b Rout=%b Extern=%b Gout=%b", i, Rin, Rout, Extern, Gout);
            end
            if (phase == 0) begin
                if (exec) begin
                    ir = instr;
                    phase = 1;
                end
            end else if (adv) begin
                if (phase == 3 || (phase == 1 && ir[9:6] < 4'd2)) phase = 0;
                else phase++;
            end
        end
`ifdef STEP_MODE_EN
        STEP = 1'b1;
`endif
    endtask

`ifdef STEP_MODE_EN
    task automatic test_step();
        logic [9:0] ir;
        int ain, gin, rin;
        ir = 10'b0101_00_11_00;
        ain = 0; gin = 0; rin = 0;
        STEP = 1'b0;
        drive(ir, 1'b1, 1'b1);
        for (int k = 0; k < 13; k++) begin
            STEP = (k % 4 == 3);
            drive(ir, 1'b0, 1'b1);
            checks++;
            if (obsOut() !== expOut((k < 12) ? 1 + k / 4 : 0, ir, 1'b0, STEP)) begin
                errors++;
                $display("[TB] FAIL step_hold k=%0d: got %h", k, obsOut());
            end
            ain += int'(Ain);
            gin += int'(Gin);
            rin += int'(Rin != 0);
        end
        checks++;
        if (ain != 1 || gin != 1 || rin != 1) begin
            errors++;
            $display("[TB] FAIL step_pulses: Ain=%0d Gin=%0d Rin=%0d expected 1 1 1", ain, gin, rin);
        end
        STEP = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        EXEC  = 1'b1;
        INSTR = '0;
`ifdef STEP_MODE_EN
        STEP  = 1'b1;
`endif
        test_reset();
        test_load();
        test_mov();
        test_alu();
        test_abort();
        test_back_to_back();
        test_random();
`ifdef STEP_MODE_EN
        test_step();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/processor_controller.md
PROCESSOR_CONTROLLER -- requirements
Module: processor_controller

Interface
REQ-001: The block SHALL have one clock and a synchronous, active-low reset.
REQ-002: clk  input  1  system clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-004: INSTR  input  10  instruction word:
- [9:6] opcode
- [5:4] Rx (destination / first operand)
- [3:2] Ry (second operand)
- [1:0] ignored
REQ-005: EXEC  input  1  request to execute INSTR.
REQ-006: IRin  output  1  pulse marking the cycle in which INSTR is captured.
REQ-007: Rin  output  4  one-hot register write enable.
REQ-008: Rout  output  4  one-hot register bus-drive enable.
REQ-009: Extern  output  1  drives external data (INSTR-side data path) onto the bus.
REQ-010: Ain  output  1  ALU A-register load; connects to the ALU Ain input.
REQ-011: Gin  output  1  ALU G-register load; connects to the ALU Gin input.
REQ-012: Gout  output  1  ALU result onto bus; connects to the ALU Gout input.
REQ-013: FN  output  4  ALU function; connects to the ALU FN input.
REQ-014: Done  output  1  one-cycle pulse marking instruction completion.
REQ-015: Busy  output  1  high in every state except T0.
REQ-016: STEP  input  1  advance strobe; the port SHALL be present only when STEP_MODE_EN is defined.

Function
REQ-017: Opcode decode SHALL be:
- 0000 LOAD (Rx <- external data)
- 0001 MOV (Rx <- Ry)
- 0010-1111 ALU operation with FN = opcode (Rx <- Rx op Ry).
REQ-018: FSM states SHALL be T0 (idle), T1, T2, T3, encoded in a 2-bit state register.
REQ-019: In T0 with EXEC=1, the block SHALL assert IRin, latch INSTR into an internal 10-bit IR, and go to T1; with EXEC=0 it SHALL stay in T0.
REQ-020: In T1 for LOAD, outputs SHALL be Extern=1, Rin=onehot(Rx), Done=1; next state T0.
REQ-021: In T1 for MOV, outputs SHALL be Rout=onehot(Ry), Rin=onehot(Rx), Done=1; next state T0.
REQ-022: In T1 for an ALU op, outputs SHALL be Rout=onehot(Rx), Ain=1; next state T2.
REQ-023: In T2 for an ALU op, outputs SHALL be Rout=onehot(Ry), Gin=1; next state T3.
REQ-024: In T3 for an ALU op, outputs SHALL be Gout=1, Rin=onehot(Rx), Done=1; next state T0.
REQ-025: FN SHALL equal the IR opcode in T1-T3 of ALU ops and 0000 otherwise.
REQ-026: Outputs SHALL be decoded combinationally from the state and the latched IR only; changes on INSTR after capture SHALL have no effect.
REQ-027: At most one Rin bit and at most one Rout bit SHALL be high in any cycle.
REQ-028: Extern, Gout and Rout SHALL be mutually exclusive (single bus driver).
REQ-029: EXEC SHALL be ignored outside T0; no queuing.
REQ-030: Back-to-back operation: EXEC held high SHALL start the next instruction in the cycle after Done, with no idle gap beyond T0.
REQ-031: Rx == Ry SHALL execute normally (e.g. R2 <- R2 op R2).
REQ-032: Latency from the IRin cycle to Done SHALL be 1 cycle for LOAD/MOV and 3 cycles for ALU ops (no STEP mode).

Reset
REQ-033: While rst_n=0 at a clock edge, the state SHALL become T0 and IR SHALL become 0.
REQ-034: In reset, all outputs SHALL be 0, with IRin=0 while rst_n=0.
REQ-035: Reset asserted mid-instruction SHALL abort the instruction with no Rin or Done asserted in the following cycle.

Configuration
REQ-036: STEP_MODE_EN defined: transitions out of T1, T2 and T3 SHALL occur only on cycles with STEP=1, and outputs SHALL hold while waiting.
REQ-037: STEP_MODE_EN defined: Rin, Ain and Gin SHALL be asserted only in the cycle where STEP=1, so each register is written exactly once.
REQ-038: STEP_MODE_EN defined: Done SHALL likewise be asserted only in the cycle where STEP=1.
REQ-039: STEP_MODE_EN undefined: the STEP port SHALL be absent and every state SHALL advance each clock.

Verification
REQ-040: Reset held 3 cycles with EXEC=1 -> all outputs 0, Busy=0; IRin first high in the cycle after rst_n rises.
REQ-041: INSTR=0000_01_00_00 (LOAD R1), EXEC pulse -> next cycle Extern=1, Rin=0010, Done=1; following cycle Busy=0.
REQ-042: INSTR=0001_11_10_00 (MOV R3,R2) -> T1 Rout=0100, Rin=1000, Done=1.
REQ-043: INSTR=0101_00_11_00 (ALU fn 0101 R0,R3) -> sequence:
- T1: Rout=0001, Ain=1
- T2: Rout=1000, Gin=1
- T3: Gout=1, Rin=0001, Done=1
- FN=0101 throughout T1-T3
REQ-044: ALU op started, INSTR changed and EXEC re-pulsed in T2, rst_n=0 in T3 -> new INSTR ignored; Rin stays 0000 and Done stays 0 after reset; state T0.
REQ-045: STEP_MODE_EN build, ALU op with STEP high once every 4 cycles -> each of T1-T3 held for 4 cycles; Ain, Gin and Rin each pulse exactly once.
